// File: rtl/spi_ram.sv
// spi_ram: byte RAM driven by 10-bit SPI command frames; optional SPI_RAM_ADDR_AUTOINC_EN post-increments addresses.
// Read data and err appear one clock after the frame; no backpressure, one frame accepted per rx_valid cycle.
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_vld;
  logic                 rd_vld;
  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] din_addr;
  logic                 do_write;

  assign opcode   = din[9:8];
  // Addresses are folded into range on capture, so the registers never leave 0..MEM_DEPTH-1.
  assign din_addr = ADDR_SIZE'(32'(din[ADDR_SIZE-1:0]) % MEM_DEPTH);
  assign do_write = rx_valid && (opcode == OP_WR_DATA) && wr_vld;

`ifdef SPI_RAM_ADDR_AUTOINC_EN
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction
`endif

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_addr] <= din[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout     <= 8'h00;
      tx_valid <= 1'b0;
      err      <= 1'b0;
      wr_vld   <= 1'b0;
      rd_vld   <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
    end else begin
      tx_valid <= 1'b0;
      err      <= 1'b0;
      if (rx_valid) begin
        case (opcode)
          OP_WR_ADDR: begin
            wr_addr <= din_addr;
            wr_vld  <= 1'b1;
          end
          OP_WR_DATA: begin
            if (!wr_vld) begin
              err <= 1'b1;
            end
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            else begin
              wr_addr <= next_addr(wr_addr);
            end
`endif
          end
          OP_RD_ADDR: begin
            rd_addr <= din_addr;
            rd_vld  <= 1'b1;
          end
          OP_RD_DATA: begin
            // The write port updates mem on the previous edge, so a read one frame later sees it.
            if (rd_vld) begin
              dout     <= mem[rd_addr];
              tx_valid <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
              rd_addr  <= next_addr(rd_addr);
`endif
            end else begin
              err <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
